// File: rtl/shift_dispatch_pkg.sv
// Shared shift definitions: data/amount/op widths, op codes, request record and
// dispatch FSM state encodings. Used by shift_dispatch, its interface and its FIFO.
package shift_dispatch_pkg;

  localparam int unsigned WIDTH       = 32;
  localparam int unsigned SHIFT_WIDTH = 5;
  localparam int unsigned OPS         = 2;

  // Shifter op codes.
  localparam logic [OPS-1:0] LEFT_SHIFTA  = 2'd0;
  localparam logic [OPS-1:0] LEFT_SHIFTL  = 2'd1;
  localparam logic [OPS-1:0] RIGHT_SHIFTA = 2'd2;
  localparam logic [OPS-1:0] RIGHT_SHIFTL = 2'd3;

  // One buffered request; op sits in the top bits so it travels with its operands.
  typedef struct packed {
    logic [OPS-1:0]         op;
    logic [SHIFT_WIDTH-1:0] shift;
    logic [WIDTH-1:0]       data;
  } shift_req_t;

  // Dispatch FSM states.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StHold  = 2'd2
  } dispatch_state_e;

  // Width of a counter that must hold 0..max_val; never narrower than one bit.
  function automatic int unsigned cnt_width(int unsigned max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/shift_dispatch_if.sv
// shift_dispatch_if: request port, shifter port and result port of shift_dispatch.
// slave is the dispatcher's view; master is the surrounding environment's view.
interface shift_dispatch_if;
  import shift_dispatch_pkg::*;

  // Request port.
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic [SHIFT_WIDTH-1:0] in_shift;
  logic [OPS-1:0]         in_op;

  // Shifter port.
  logic [WIDTH-1:0]       sh_data;
  logic [SHIFT_WIDTH-1:0] sh_shift;
  logic [OPS-1:0]         sh_op;
  logic                   sh_start;
  logic [WIDTH-1:0]       sh_result;

  // Result port.
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_result;
  logic [OPS-1:0]         out_op;

  modport slave (
    input  in_valid, in_data, in_shift, in_op,
    output in_ready,
    output sh_data, sh_shift, sh_op, sh_start,
    input  sh_result,
    output out_valid, out_result, out_op,
    input  out_ready
  );

  modport master (
    output in_valid, in_data, in_shift, in_op,
    input  in_ready,
    input  sh_data, sh_shift, sh_op, sh_start,
    output sh_result,
    input  out_valid, out_result, out_op,
    output out_ready
  );

endinterface

// File: rtl/shift_req_fifo.sv
// shift_req_fifo: synchronous request FIFO with registered count, no fall-through.
// DEPTH must be a power of two (>= 2) so the pointers wrap by natural overflow.
module shift_req_fifo
  import shift_dispatch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  shift_req_t                 wdata,
  input  logic                       pop,
  output shift_req_t                 rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  shift_req_t      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  // A push into a full FIFO is dropped even if a pop happens the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage; contents are only meaningful below count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/shift_dispatch.sv
// shift_dispatch: buffers shift requests, issues them one at a time to the ALU
// shifter, captures the result SHIFT_LAT cycles into the issue window and holds it
// on a valid/ready result port. Results leave in request order.
// Build macro SHIFT_DISPATCH_STATS_EN adds the stat_issued/stat_stall counters.
module shift_dispatch
  import shift_dispatch_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,  // FIFO entries, power of two >= 2
  parameter int unsigned SHIFT_LAT = 0   // extra cycles from issue to capture
) (
  input  logic            clk,
  input  logic            rst_n,
  shift_dispatch_if.slave bus
`ifdef SHIFT_DISPATCH_STATS_EN
  ,
  output logic [31:0]     stat_issued,
  output logic [31:0]     stat_stall
`endif
);

  localparam int unsigned WaitW    = cnt_width(SHIFT_LAT);
  localparam int unsigned FifoCntW = $clog2(DEPTH + 1);

  dispatch_state_e        state_q, state_d;
  logic [WaitW-1:0]       wait_q, wait_d;
  logic [WIDTH-1:0]       sh_data_q, sh_data_d;
  logic [SHIFT_WIDTH-1:0] sh_shift_q, sh_shift_d;
  logic [OPS-1:0]         sh_op_q, sh_op_d;
  logic                   sh_start_q, sh_start_d;
  logic                   out_valid_q, out_valid_d;
  logic [WIDTH-1:0]       out_result_q, out_result_d;
  logic [OPS-1:0]         out_op_q, out_op_d;

  shift_req_t             fifo_wdata, fifo_head;
  logic                   fifo_full, fifo_empty;
  logic [FifoCntW-1:0]    fifo_count;
  logic                   push, pop;

  // in_ready depends only on the registered FIFO count.
  assign bus.in_ready = !fifo_full;
  assign push         = bus.in_valid && !fifo_full;
  assign fifo_wdata   = '{op: bus.in_op, shift: bus.in_shift, data: bus.in_data};

  // A new request may start only when the shifter is free or its result is leaving.
  assign pop = !fifo_empty &&
               ((state_q == StIdle) || ((state_q == StHold) && bus.out_ready));

  shift_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Next-state logic: load issue registers on pop, capture result at end of wait.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    sh_data_d    = sh_data_q;
    sh_shift_d   = sh_shift_q;
    sh_op_d      = sh_op_q;
    sh_start_d   = sh_start_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_op_d     = out_op_q;

    unique case (state_q)
      StIdle: begin
        if (pop) begin
          state_d    = StIssue;
          wait_d     = '0;
          sh_data_d  = fifo_head.data;
          sh_shift_d = fifo_head.shift;
          sh_op_d    = fifo_head.op;
          sh_start_d = 1'b1;
        end
      end

      StIssue: begin
        if (wait_q == WaitW'(SHIFT_LAT)) begin
          state_d      = StHold;
          out_result_d = bus.sh_result;
          out_op_d     = sh_op_q;
          out_valid_d  = 1'b1;
          sh_start_d   = 1'b0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      StHold: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (pop) begin
            state_d    = StIssue;
            wait_d     = '0;
            sh_data_d  = fifo_head.data;
            sh_shift_d = fifo_head.shift;
            sh_op_d    = fifo_head.op;
            sh_start_d = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, issue and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      wait_q       <= '0;
      sh_data_q    <= '0;
      sh_shift_q   <= '0;
      sh_op_q      <= '0;
      sh_start_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_op_q     <= '0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      sh_data_q    <= sh_data_d;
      sh_shift_q   <= sh_shift_d;
      sh_op_q      <= sh_op_d;
      sh_start_q   <= sh_start_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_op_q     <= out_op_d;
    end
  end

  assign bus.sh_data    = sh_data_q;
  assign bus.sh_shift   = sh_shift_q;
  assign bus.sh_op      = sh_op_q;
  assign bus.sh_start   = sh_start_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_op     = out_op_q;

`ifdef SHIFT_DISPATCH_STATS_EN
  logic [31:0] stat_issued_q, stat_stall_q;

  // Every pop is an IDLE/HOLD -> ISSUE transition; stalls are held-but-refused cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      if (pop)                           stat_issued_q <= stat_issued_q + 32'd1;
      if (out_valid_q && !bus.out_ready) stat_stall_q  <= stat_stall_q + 32'd1;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_stall  = stat_stall_q;
`endif

  // Structural invariants between the FSM, the shifter strobe and the FIFO.
  a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
    fifo_count <= FifoCntW'(DEPTH));
  a_start_in_issue : assert property (@(posedge clk) disable iff (!rst_n)
    sh_start_q == (state_q == StIssue));
  a_valid_in_hold : assert property (@(posedge clk) disable iff (!rst_n)
    out_valid_q == (state_q == StHold));

endmodule

// File: tb/tb_shift_dispatch.sv
// Bench for shift_dispatch: directed vector table, multi-cycle corner sequences and
// randomized traffic scored against an arithmetic reference of the shift ops.
module tb_shift_dispatch;
  import shift_dispatch_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  shift_dispatch_if if0 ();
  shift_dispatch_if if3 ();

`ifdef SHIFT_DISPATCH_STATS_EN
  logic [31:0] st0_issued, st0_stall, st3_issued, st3_stall;
`endif

  shift_dispatch #(.DEPTH(4), .SHIFT_LAT(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
`ifdef SHIFT_DISPATCH_STATS_EN
    ,
    .stat_issued (st0_issued),
    .stat_stall  (st0_stall)
`endif
  );

  shift_dispatch #(.DEPTH(4), .SHIFT_LAT(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if3)
`ifdef SHIFT_DISPATCH_STATS_EN
    ,
    .stat_issued (st3_issued),
    .stat_stall  (st3_stall)
`endif
  );

  // Shifter stand-in built on the language shift operators.
  function automatic logic [31:0] shifter(logic [31:0] d, logic [4:0] s, logic [1:0] op);
    case (op)
      LEFT_SHIFTA, LEFT_SHIFTL: return d << s;
      RIGHT_SHIFTA:             return 32'($signed(d) >>> s);
      default:                  return d >> s;
    endcase
  endfunction

  assign if0.sh_result = shifter(if0.sh_data, if0.sh_shift, if0.sh_op);
  assign if3.sh_result = shifter(if3.sh_data, if3.sh_shift, if3.sh_op);

  // Reference: shifts as multiply / floor-divide by a power of two.
  function automatic logic [31:0] ref_shift(logic [31:0] d, logic [4:0] s, logic [1:0] op);
    longint p, x, q;
    p = longint'(1) << s;
    if (op == LEFT_SHIFTA || op == LEFT_SHIFTL) begin
      q = longint'(d) * p;
    end else if (op == RIGHT_SHIFTL) begin
      q = longint'(d) / p;
    end else begin
      x = d[31] ? (longint'(d) - 64'sd4294967296) : longint'(d);
      q = (x >= 0) ? (x / p) : -((-x + p - 1) / p);
    end
    return q[31:0];
  endfunction

  typedef struct packed {
    logic [31:0] result;
    logic [1:0]  op;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic [4:0]  shift;
    logic [31:0] result;
  } vec_t;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  int unsigned acc_cnt = 0;
  int unsigned out_cnt = 0;
  exp_t        exp_q[$];
  int unsigned out_cyc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, want);
    end
  endtask

  // Advance one clock; score dut0 handshakes seen at that edge against the model.
  task automatic step();
    logic in_hs, out_hs;
    exp_t req_exp, got, want;
    in_hs          = rst_n && if0.in_valid && if0.in_ready;
    out_hs         = rst_n && if0.out_valid && if0.out_ready;
    req_exp.result = ref_shift(if0.in_data, if0.in_shift, if0.in_op);
    req_exp.op     = if0.in_op;
    got.result     = if0.out_result;
    got.op         = if0.out_op;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      return;
    end
    if (out_hs) begin
      out_cnt++;
      out_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL model_unexpected: got result 0x%08h, required no result", got.result);
      end else begin
        want = exp_q.pop_front();
        check("model_result", got.result, want.result);
        check("model_op", 32'(got.op), 32'(want.op));
      end
    end
    if (in_hs) begin
      exp_q.push_back(req_exp);
      acc_cnt++;
    end
  endtask

  task automatic drive0(input logic v, input logic [31:0] d, input logic [4:0] s,
                        input logic [1:0] op);
    if0.in_valid = v;
    if0.in_data  = d;
    if0.in_shift = s;
    if0.in_op    = op;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[8];
    logic [31:0] cap_data[8];
    logic [4:0]  cap_shift[8];
    logic [1:0]  cap_op[8];
    int          lat, starts, idx, bound, seen, stalls;
    int unsigned acc0, out0;

    vecs[0] = '{RIGHT_SHIFTA, 32'h8000_0000, 5'd5,  32'hFC00_0000};
    vecs[1] = '{RIGHT_SHIFTL, 32'h8000_0000, 5'd5,  32'h0400_0000};
    vecs[2] = '{LEFT_SHIFTL,  32'h0000_0003, 5'd5,  32'h0000_0060};
    vecs[3] = '{LEFT_SHIFTA,  32'h0000_0001, 5'd31, 32'h8000_0000};
    vecs[4] = '{RIGHT_SHIFTA, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000};
    vecs[5] = '{RIGHT_SHIFTA, 32'hFFFF_FFF0, 5'd4,  32'hFFFF_FFFF};
    vecs[6] = '{LEFT_SHIFTL,  32'h1234_5678, 5'd0,  32'h1234_5678};
    vecs[7] = '{RIGHT_SHIFTL, 32'hF000_0000, 5'd28, 32'h0000_000F};

    rst_n = 1'b0;
    drive0(1'b0, '0, '0, '0);
    if0.out_ready = 1'b1;
    if3.in_valid  = 1'b0;
    if3.in_data   = '0;
    if3.in_shift  = '0;
    if3.in_op     = '0;
    if3.out_ready = 1'b1;
    step();
    step();

    // Reset values.
    check("rst_in_ready",   32'(if0.in_ready),   32'd1);
    check("rst_out_valid",  32'(if0.out_valid),  32'd0);
    check("rst_out_result", if0.out_result,      32'd0);
    check("rst_out_op",     32'(if0.out_op),     32'd0);
    check("rst_sh_data",    if0.sh_data,         32'd0);
    check("rst_sh_shift",   32'(if0.sh_shift),   32'd0);
    check("rst_sh_op",      32'(if0.sh_op),      32'd0);
    check("rst_sh_start",   32'(if0.sh_start),   32'd0);
    rst_n = 1'b1;
    step();

    // Directed vectors, one at a time from idle.
    for (int i = 0; i < 8; i++) begin
      drive0(1'b1, vecs[i].data, vecs[i].shift, vecs[i].op);
      check("vec_in_ready", 32'(if0.in_ready), 32'd1);
      step();
      if0.in_valid = 1'b0;
      lat = 0;
      while (!if0.out_valid && lat < 20) begin
        step();
        lat++;
      end
      check("vec_latency", 32'(lat), 32'd2);
      check("vec_result", if0.out_result, vecs[i].result);
      check("vec_op", 32'(if0.out_op), 32'(vecs[i].op));
      step();
    end

    // Back-to-back with out_ready high: one result every 2 cycles.
    out_cyc_q.delete();
    for (int k = 0; k < 4; k++) begin
      drive0(1'b1, vecs[k].data, vecs[k].shift, vecs[k].op);
      check("b2b_in_ready", 32'(if0.in_ready), 32'd1);
      step();
    end
    if0.in_valid = 1'b0;
    bound = 0;
    while (out_cyc_q.size() < 4 && bound < 40) begin
      step();
      bound++;
    end
    check("b2b_count", 32'(out_cyc_q.size()), 32'd4);
    for (int k = 1; k < 4; k++) begin
      if (out_cyc_q.size() > k) check("b2b_spacing", out_cyc_q[k] - out_cyc_q[k-1], 32'd2);
    end

    // Capacity: DEPTH+1 accepted while the result port is blocked.
    for (int k = 0; k < 8; k++) begin
      cap_data[k]  = $urandom();
      cap_shift[k] = 5'($urandom());
      cap_op[k]    = 2'($urandom());
    end
    if0.out_ready = 1'b0;
    acc0 = acc_cnt;
    idx  = 0;
    drive0(1'b1, cap_data[0], cap_shift[0], cap_op[0]);
    repeat (12) begin
      step();
      if (acc_cnt - acc0 > idx) begin
        idx++;
        if (idx < 8) drive0(1'b1, cap_data[idx], cap_shift[idx], cap_op[idx]);
        else if0.in_valid = 1'b0;
      end
    end
    check("cap_accepted",  acc_cnt - acc0,       32'd5);
    check("cap_in_ready",  32'(if0.in_ready),    32'd0);
    check("cap_out_valid", 32'(if0.out_valid),   32'd1);
    check("cap_held",      if0.out_result,
          ref_shift(cap_data[0], cap_shift[0], cap_op[0]));
    if0.out_ready = 1'b1;
    out0  = out_cnt - 0;
    bound = 0;
    while ((idx < 8 || exp_q.size() > 0) && bound < 80) begin
      step();
      bound++;
      if (acc_cnt - acc0 > idx) begin
        idx++;
        if (idx < 8) drive0(1'b1, cap_data[idx], cap_shift[idx], cap_op[idx]);
        else if0.in_valid = 1'b0;
      end
    end
    check("cap_total_acc", acc_cnt - acc0, 32'd8);
    check("cap_total_out", out_cnt - out0, 32'd8);

    // SHIFT_LAT = 3: accept-to-valid 5 cycles, sh_start high for 4.
    if3.in_valid = 1'b1;
    if3.in_data  = 32'h0000_0001;
    if3.in_shift = 5'd31;
    if3.in_op    = LEFT_SHIFTA;
    step();
    if3.in_valid = 1'b0;
    lat    = 0;
    starts = 0;
    while (!if3.out_valid && lat < 30) begin
      step();
      lat++;
      if (if3.sh_start) starts++;
    end
    check("lat3_latency", 32'(lat),          32'd5);
    check("lat3_start",   32'(starts),       32'd4);
    check("lat3_result",  if3.out_result,    32'h8000_0000);
    check("lat3_op",      32'(if3.out_op),   32'(LEFT_SHIFTA));
    step();

    // Randomized traffic on dut0 against the reference queue.
    acc0 = acc_cnt;
    out0 = out_cnt;
    repeat (400) begin
      drive0($urandom_range(0, 99) < 60, $urandom(), 5'($urandom()), 2'($urandom()));
      if0.out_ready = ($urandom_range(0, 99) < 70);
      step();
    end
    if0.in_valid  = 1'b0;
    if0.out_ready = 1'b1;
    bound = 0;
    while ((exp_q.size() > 0 || if0.out_valid) && bound < 60) begin
      step();
      bound++;
    end
    check("rand_drained", 32'(exp_q.size()), 32'd0);
    check("rand_count",   out_cnt - out0,    acc_cnt - acc0);

    // Reset in the middle of an ISSUE window with 3 requests queued.
    for (int k = 0; k < 4; k++) begin
      if3.in_valid = 1'b1;
      if3.in_data  = 32'hA5A5_0000 + 32'(k);
      if3.in_shift = 5'(k + 1);
      if3.in_op    = RIGHT_SHIFTL;
      step();
    end
    if3.in_valid = 1'b0;
    check("rst_mid_issue", 32'(if3.sh_start), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstm_in_ready",   32'(if3.in_ready),   32'd1);
    check("rstm_out_valid",  32'(if3.out_valid),  32'd0);
    check("rstm_out_result", if3.out_result,      32'd0);
    check("rstm_out_op",     32'(if3.out_op),     32'd0);
    check("rstm_sh_data",    if3.sh_data,         32'd0);
    check("rstm_sh_shift",   32'(if3.sh_shift),   32'd0);
    check("rstm_sh_op",      32'(if3.sh_op),      32'd0);
    check("rstm_sh_start",   32'(if3.sh_start),   32'd0);
    step();
    step();
    rst_n = 1'b1;
    seen  = 0;
    repeat (12) begin
      step();
      if (if3.out_valid || if3.sh_start) seen++;
    end
    check("rstm_no_stale", 32'(seen),        32'd0);
    check("rstm_ready",    32'(if3.in_ready), 32'd1);

`ifdef SHIFT_DISPATCH_STATS_EN
    // Counters: 4 issues, 3 refused cycles on the first result.
    check("stat_rst_issued", st0_issued, 32'd0);
    check("stat_rst_stall",  st0_stall,  32'd0);
    if0.out_ready = 1'b0;
    acc0   = acc_cnt;
    idx    = 0;
    stalls = 0;
    bound  = 0;
    drive0(1'b1, vecs[0].data, vecs[0].shift, vecs[0].op);
    while ((idx < 4 || exp_q.size() > 0 || if0.out_valid) && bound < 60) begin
      step();
      bound++;
      if (acc_cnt - acc0 > idx) begin
        idx++;
        if (idx < 4) drive0(1'b1, vecs[idx].data, vecs[idx].shift, vecs[idx].op);
        else if0.in_valid = 1'b0;
      end
      if (if0.out_valid && !if0.out_ready) begin
        if (stalls == 3) if0.out_ready = 1'b1;
        else stalls++;
      end
    end
    check("stat_issued", st0_issued, 32'd4);
    check("stat_stall",  st0_stall,  32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
